cache_manage_ctrl: RTL and testbench

//  Split L1 cache manager between the CPU pipeline and the DDR block controller.

---
 rtl/cache_manage_ctrl_if.sv | 49 ++++
 rtl/cache_manage_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_cache_manage_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_manage_ctrl_if.sv
// ============================================================================
// cache_manage_ctrl_if : CPU-side and RAM-side signal bundle of cache_manage_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cache_manage_ctrl_if;
  logic         dc_read_in;
  logic         dc_write_in;
  logic [3:0]   dc_byte_w_en_in;
  logic [29:0]  ic_addr;
  logic [29:0]  dc_addr;
  logic [31:0]  data_from_reg;
  logic         ram_ready;
  logic [255:0] block_from_ram;
  logic         mem_stall;
  logic [31:0]  dc_data_out;
  logic [31:0]  ic_data_out;
  logic         ram_en_out;
  logic         ram_write_out;
  logic [29:0]  ram_addr_out;
  logic [255:0] dc_data_wb;
`ifdef CMU_PERF_CNT_EN
  logic [31:0]  ic_miss_cnt;
  logic [31:0]  dc_miss_cnt;
`endif

  modport slave (
`ifdef CMU_PERF_CNT_EN
    output ic_miss_cnt, dc_miss_cnt,
`endif
    input  dc_read_in, dc_write_in, dc_byte_w_en_in, ic_addr, dc_addr,
    input  data_from_reg, ram_ready, block_from_ram,
    output mem_stall, dc_data_out, ic_data_out, ram_en_out, ram_write_out,
    output ram_addr_out, dc_data_wb
  );

  modport master (
`ifdef CMU_PERF_CNT_EN
    input  ic_miss_cnt, dc_miss_cnt,
`endif
    output dc_read_in, dc_write_in, dc_byte_w_en_in, ic_addr, dc_addr,
    output data_from_reg, ram_ready, block_from_ram,
    input  mem_stall, dc_data_out, ic_data_out, ram_en_out, ram_write_out,
    input  ram_addr_out, dc_data_wb
  );
endinterface

`default_nettype wire

// File: rtl/cache_manage_ctrl.sv
// ============================================================================
// cache_manage_ctrl : split direct-mapped I/D L1 manager sharing one block RAM port
// Optional miss counters enabled by defining CMU_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_manage_ctrl #(
  parameter int IDX_W = 6
) (
  input  wire logic           clk,
  input  wire logic           rst,
  cache_manage_ctrl_if.slave  bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {IDLE, DC_WB, DC_FILL, IC_FILL} state_t;

  state_t state_q, state_d;
  logic ram_en_q, ram_en_d, ram_write_q, ram_write_d;
  logic [29:0] ram_addr_q, ram_addr_d;
  logic [LINES-1:0] ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d, dc_dirty_q, dc_dirty_d;

  // Data and tag arrays are intentionally left uninitialised by reset.
  logic [255:0]     ic_data_q [LINES];
  logic [255:0]     dc_data_q [LINES];
  logic [TAG_W-1:0] ic_tag_q  [LINES];
  logic [TAG_W-1:0] dc_tag_q  [LINES];

  logic [IDX_W-1:0] ic_idx, dc_idx, fill_idx, dc_wr_idx;
  logic [TAG_W-1:0] ic_tag, dc_tag, fill_tag, dc_wr_tag;
  logic [2:0]       ic_off, dc_off;
  logic [255:0]     ic_line, dc_line, dc_wr_line;
  logic [31:0]      dc_word, dc_merged;
  logic ic_hit, dc_hit, dc_acc, ic_wr_en, dc_wr_en;

`ifdef CMU_PERF_CNT_EN
  logic [31:0] ic_miss_cnt_q, ic_miss_cnt_d, dc_miss_cnt_q, dc_miss_cnt_d;
  assign bus.ic_miss_cnt = ic_miss_cnt_q;
  assign bus.dc_miss_cnt = dc_miss_cnt_q;
`endif

  assign ic_idx   = bus.ic_addr[3+IDX_W-1:3];
  assign ic_tag   = bus.ic_addr[29:3+IDX_W];
  assign ic_off   = bus.ic_addr[2:0];
  assign dc_idx   = bus.dc_addr[3+IDX_W-1:3];
  assign dc_tag   = bus.dc_addr[29:3+IDX_W];
  assign dc_off   = bus.dc_addr[2:0];
  assign fill_idx = ram_addr_q[3+IDX_W-1:3];
  assign fill_tag = ram_addr_q[29:3+IDX_W];

  assign ic_line = ic_data_q[ic_idx];
  assign dc_line = dc_data_q[dc_idx];
  assign ic_hit  = ic_valid_q[ic_idx] && (ic_tag_q[ic_idx] == ic_tag);
  assign dc_hit  = dc_valid_q[dc_idx] && (dc_tag_q[dc_idx] == dc_tag);
  assign dc_acc  = bus.dc_read_in | bus.dc_write_in;
  assign dc_word = dc_line[{dc_off, 5'd0} +: 32];

  assign bus.ic_data_out   = ic_hit ? ic_line[{ic_off, 5'd0} +: 32] : 32'd0;
  assign bus.dc_data_out   = dc_hit ? dc_word : 32'd0;
  assign bus.mem_stall     = (state_q != IDLE) | ~ic_hit | (dc_acc & ~dc_hit);
  assign bus.ram_en_out    = ram_en_q;
  assign bus.ram_write_out = ram_write_q;
  assign bus.ram_addr_out  = ram_addr_q;
  // The victim line is untouched while DC_WB is active, so read it straight from the array.
  assign bus.dc_data_wb    = (state_q == DC_WB) ? dc_data_q[fill_idx] : 256'd0;

  always_comb begin
    dc_merged = dc_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.dc_byte_w_en_in[b]) dc_merged[8*b +: 8] = bus.data_from_reg[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_en_d    = ram_en_q;
    ram_write_d = ram_write_q;
    ram_addr_d  = ram_addr_q;
    ic_valid_d  = ic_valid_q;
    dc_valid_d  = dc_valid_q;
    dc_dirty_d  = dc_dirty_q;
    ic_wr_en    = 1'b0;
    dc_wr_en    = 1'b0;
    dc_wr_idx   = dc_idx;
    dc_wr_tag   = dc_tag;
    dc_wr_line  = dc_line;
    dc_wr_line[{dc_off, 5'd0} +: 32] = dc_merged;
`ifdef CMU_PERF_CNT_EN
    ic_miss_cnt_d = ic_miss_cnt_q;
    dc_miss_cnt_d = dc_miss_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (dc_acc && !dc_hit) begin
          ram_en_d = 1'b1;
          if (dc_valid_q[dc_idx] && dc_dirty_q[dc_idx]) begin
            state_d     = DC_WB;
            ram_write_d = 1'b1;
            ram_addr_d  = {dc_tag_q[dc_idx], dc_idx, 3'b000};
          end else begin
            state_d     = DC_FILL;
            ram_write_d = 1'b0;
            ram_addr_d  = {bus.dc_addr[29:3], 3'b000};
          end
        end else if (!ic_hit) begin
          state_d     = IC_FILL;
          ram_en_d    = 1'b1;
          ram_write_d = 1'b0;
          ram_addr_d  = {bus.ic_addr[29:3], 3'b000};
        end else if (bus.dc_write_in) begin
          dc_wr_en           = 1'b1;
          dc_dirty_d[dc_idx] = 1'b1;
        end
      end
      DC_WB: begin
        if (bus.ram_ready) begin
          state_d              = DC_FILL;
          dc_dirty_d[fill_idx] = 1'b0;
          ram_write_d          = 1'b0;
          ram_addr_d           = {bus.dc_addr[29:3], 3'b000};
        end
      end
      DC_FILL: begin
        if (bus.ram_ready) begin
          state_d              = IDLE;
          ram_en_d             = 1'b0;
          ram_write_d          = 1'b0;
          dc_wr_en             = 1'b1;
          dc_wr_idx            = fill_idx;
          dc_wr_tag            = fill_tag;
          dc_wr_line           = bus.block_from_ram;
          dc_valid_d[fill_idx] = 1'b1;
          dc_dirty_d[fill_idx] = 1'b0;
`ifdef CMU_PERF_CNT_EN
          dc_miss_cnt_d = dc_miss_cnt_q + 32'd1;
`endif
        end
      end
      IC_FILL: begin
        if (bus.ram_ready) begin
          state_d              = IDLE;
          ram_en_d             = 1'b0;
          ram_write_d          = 1'b0;
          ic_wr_en             = 1'b1;
          ic_valid_d[fill_idx] = 1'b1;
`ifdef CMU_PERF_CNT_EN
          ic_miss_cnt_d = ic_miss_cnt_q + 32'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ram_en_q    <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= 30'd0;
      ic_valid_q  <= '0;
      dc_valid_q  <= '0;
      dc_dirty_q  <= '0;
`ifdef CMU_PERF_CNT_EN
      ic_miss_cnt_q <= 32'd0;
      dc_miss_cnt_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ic_valid_q  <= ic_valid_d;
      dc_valid_q  <= dc_valid_d;
      dc_dirty_q  <= dc_dirty_d;
`ifdef CMU_PERF_CNT_EN
      ic_miss_cnt_q <= ic_miss_cnt_d;
      dc_miss_cnt_q <= dc_miss_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (dc_wr_en) begin
      dc_data_q[dc_wr_idx] <= dc_wr_line;
      dc_tag_q[dc_wr_idx]  <= dc_wr_tag;
    end
    if (ic_wr_en) begin
      ic_data_q[fill_idx] <= bus.block_from_ram;
      ic_tag_q[fill_idx]  <= fill_tag;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_cache_manage_ctrl.sv
// ============================================================================
// tb_cache_manage_ctrl : directed self-checking bench with a RAM-request scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_manage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_manage_ctrl_if bus();
  cache_manage_ctrl #(.IDX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        wr;
    logic [29:0] addr;
  } req_t;
  req_t req_q[$];

  int checks = 0;
  int passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] mk(input logic [31:0] seed, input int pos, input logic [31:0] w);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = seed + 32'(i);
    b[32*pos +: 32] = w;
    return b;
  endfunction

  function automatic logic [31:0] word(input logic [255:0] b, input int pos);
    return b[32*pos +: 32];
  endfunction

  task automatic expect_req(input logic wr, input logic [29:0] addr);
    req_t r;
    r.wr = wr;
    r.addr = addr;
    req_q.push_back(r);
  endtask

  task automatic wait_req();
    req_t r;
    int n = 0;
    while (!bus.ram_en_out && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", 256'(bus.ram_en_out), 256'd1);
    chk("req_stall", 256'(bus.mem_stall), 256'd1);
    if (req_q.size() == 0) begin
      chk("sb_nonempty", 256'd0, 256'd1);
    end else begin
      r = req_q.pop_front();
      chk("req_write", 256'(bus.ram_write_out), 256'(r.wr));
      chk("req_addr", 256'(bus.ram_addr_out), 256'(r.addr));
    end
  endtask

  task automatic respond(input logic [255:0] blk, input int lat);
    repeat (lat) tick();
    bus.block_from_ram = blk;
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    #1;
  endtask

  task automatic serve(input logic [255:0] blk, input int lat);
    wait_req();
    respond(blk, lat);
  endtask

  logic [255:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, victim;

  initial begin
    bus.dc_read_in      = 1'b0;
    bus.dc_write_in     = 1'b0;
    bus.dc_byte_w_en_in = 4'b0000;
    bus.ic_addr         = 30'h10;
    bus.dc_addr         = 30'h0;
    bus.data_from_reg   = 32'h0;
    bus.ram_ready       = 1'b0;
    bus.block_from_ram  = '0;
    blk_a = mk(32'h1000_0000, 1, 32'hAABBCCDD);
    blk_b = mk(32'h2000_0000, 1, 32'h55667788);
    blk_c = mk(32'h3000_0000, 1, 32'h0BADF00D);
    blk_d = mk(32'h4000_0000, 0, 32'hD0D0D0D0);
    blk_e = mk(32'h5000_0000, 0, 32'hE1E1E1E1);
    blk_f = mk(32'h6000_0000, 0, 32'hF2F2F2F2);

    repeat (3) tick();
    chk("rst_ram_en", 256'(bus.ram_en_out), 256'd0);
    chk("rst_ram_write", 256'(bus.ram_write_out), 256'd0);
    chk("rst_ram_addr", 256'(bus.ram_addr_out), 256'd0);
    chk("rst_cold_stall", 256'(bus.mem_stall), 256'd1);
`ifdef CMU_PERF_CNT_EN
    chk("rst_ic_cnt", 256'(bus.ic_miss_cnt), 256'd0);
    chk("rst_dc_cnt", 256'(bus.dc_miss_cnt), 256'd0);
`endif

    // Cold instruction fetch
    rst = 1'b1;
    expect_req(1'b0, 30'h10);
    serve(mk(32'h0, 0, 32'hDEADBEEF), 2);
    chk("ifetch_data", 256'(bus.ic_data_out), 256'(32'hDEADBEEF));
    chk("ifetch_stall", 256'(bus.mem_stall), 256'd0);
    chk("ifetch_en_drop", 256'(bus.ram_en_out), 256'd0);

    // Load miss then store hit with one byte lane
    bus.dc_addr = 30'h21;
    bus.dc_read_in = 1'b1;
    expect_req(1'b0, 30'h20);
    #1;
    serve(blk_a, 1);
    chk("load_data", 256'(bus.dc_data_out), 256'(32'hAABBCCDD));
    chk("load_stall", 256'(bus.mem_stall), 256'd0);
    bus.dc_read_in = 1'b0;
    bus.dc_write_in = 1'b1;
    bus.data_from_reg = 32'h11223344;
    bus.dc_byte_w_en_in = 4'b0010;
    #1;
    chk("store_hit_stall", 256'(bus.mem_stall), 256'd0);
    tick();
    bus.dc_write_in = 1'b0;
    bus.dc_read_in = 1'b1;
    #1;
    chk("store_merge", 256'(bus.dc_data_out), 256'(32'hAABB33DD));

    // Dirty eviction of 0x20 block by a load of 0x221
    victim = blk_a;
    victim[32 +: 32] = 32'hAABB33DD;
    bus.dc_addr = 30'h221;
    expect_req(1'b1, 30'h20);
    expect_req(1'b0, 30'h220);
    #1;
    wait_req();
    chk("wb_block", bus.dc_data_wb, victim);
    respond(blk_b, 3);
    serve(blk_b, 1);
    chk("evict_load", 256'(bus.dc_data_out), 256'(word(blk_b, 1)));

    // Store with no byte enables still dirties the line without changing data
    bus.dc_read_in = 1'b0;
    bus.dc_write_in = 1'b1;
    bus.dc_byte_w_en_in = 4'b0000;
    bus.data_from_reg = 32'hFFFFFFFF;
    #1;
    tick();
    bus.dc_write_in = 1'b0;
    bus.dc_read_in = 1'b1;
    bus.dc_addr = 30'h21;
    expect_req(1'b1, 30'h220);
    expect_req(1'b0, 30'h20);
    #1;
    wait_req();
    chk("zero_be_wb", bus.dc_data_wb, blk_b);
    respond(blk_c, 2);
    serve(blk_c, 2);
    chk("refill_load", 256'(bus.dc_data_out), 256'(word(blk_c, 1)));

    // Simultaneous I and D misses: data side first
    bus.dc_addr = 30'h600;
    bus.ic_addr = 30'h400;
    expect_req(1'b0, 30'h600);
    expect_req(1'b0, 30'h400);
    #1;
    serve(blk_d, 2);
    chk("dual_mid_stall", 256'(bus.mem_stall), 256'd1);
    serve(blk_e, 2);
    chk("dual_end_stall", 256'(bus.mem_stall), 256'd0);
    chk("dual_ic_data", 256'(bus.ic_data_out), 256'(word(blk_e, 0)));
    chk("dual_dc_data", 256'(bus.dc_data_out), 256'(word(blk_d, 0)));
`ifdef CMU_PERF_CNT_EN
    chk("cnt_ic", 256'(bus.ic_miss_cnt), 256'd2);
    chk("cnt_dc", 256'(bus.dc_miss_cnt), 256'd4);
`endif

    // Stray ram_ready in IDLE has no effect
    bus.block_from_ram = blk_f;
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    #1;
    chk("stray_en", 256'(bus.ram_en_out), 256'd0);
    chk("stray_stall", 256'(bus.mem_stall), 256'd0);
    chk("stray_dc_data", 256'(bus.dc_data_out), 256'(word(blk_d, 0)));

    // Reset in the middle of a data fill
    bus.dc_addr = 30'h800;
    expect_req(1'b0, 30'h800);
    #1;
    wait_req();
    rst = 1'b0;
    #1;
    chk("midrst_en", 256'(bus.ram_en_out), 256'd0);
    chk("midrst_addr", 256'(bus.ram_addr_out), 256'd0);
    chk("midrst_stall", 256'(bus.mem_stall), 256'd1);
    tick();
    bus.dc_read_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_ic_miss", 256'(bus.mem_stall), 256'd1);
    expect_req(1'b0, 30'h400);
    serve(blk_f, 1);
    chk("post_rst_ic_data", 256'(bus.ic_data_out), 256'(word(blk_f, 0)));
    bus.dc_addr = 30'h600;
    bus.dc_read_in = 1'b1;
    #1;
    chk("post_rst_dc_miss", 256'(bus.mem_stall), 256'd1);
    expect_req(1'b0, 30'h600);
    serve(blk_d, 1);
    chk("post_rst_dc_data", 256'(bus.dc_data_out), 256'(word(blk_d, 0)));
`ifdef CMU_PERF_CNT_EN
    chk("cnt_ic_after_rst", 256'(bus.ic_miss_cnt), 256'd1);
    chk("cnt_dc_after_rst", 256'(bus.dc_miss_cnt), 256'd1);
`endif
    chk("sb_drained", 256'(req_q.size()), 256'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

`default_nettype wire
